// File: rtl/mobile_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : mobile_transmitter
// Brief    : 8N1 UART transmitter fed by a small byte FIFO. Bytes written by
//            the CPU are queued and shifted out LSB first at a fixed baud
//            derived from the system clock. Back-to-back frames are sent
//            with no idle gap between the stop bit and the next start bit.
// Revision : 1.0 - initial release
// ============================================================================
module mobile_transmitter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  output logic       full_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic       tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   c_baud_last = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_depth     = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] c_ptr_one   = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          ovf_q;

  logic w_bit_end, w_empty, w_full, w_push, w_pop;

  // FIFO status and handshakes; full is judged on the registered count,
  // so a write while full is dropped even if a pop frees a slot this cycle.
  always_comb begin
    w_bit_end = (baud_q == c_baud_last);
    w_empty   = (count_q == '0);
    w_full    = (count_q == c_depth);
    w_push    = wr_en_i && !w_full;
    w_pop     = !w_empty && ((state_q == S_IDLE) ||
                             ((state_q == S_STOP) && w_bit_end));
    count_d   = count_q + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
  end

  // Byte storage; contents need no reset because the count guards reads.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  // FIFO pointers, occupancy and the one-cycle overflow pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (w_push) wptr_q <= wptr_q + c_ptr_one;
      if (w_pop)  rptr_q <= rptr_q + c_ptr_one;
      count_q <= count_d;
      ovf_q   <= wr_en_i && w_full;
    end
  end

  // Frame sequencer; tx is loaded with the level of the state being entered
  // so the line changes exactly on the bit boundary and comes from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (w_pop) begin
            shift_q <= mem_q[rptr_q];
            baud_q  <= '0;
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            baud_q <= '0;
            if (w_pop) begin
              shift_q <= mem_q[rptr_q];
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign full_o     = w_full;
  assign busy_o     = (state_q != S_IDLE) || !w_empty;
  assign overflow_o = ovf_q;
  assign tx_o       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_mobile_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mobile_transmitter
// Brief    : Self-checking bench for mobile_transmitter. A queue-based model
//            tracks the byte FIFO and the in-flight frame as an elapsed-cycle
//            count, and derives the expected line level from the frame
//            position. Directed tables and sequences cover the corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mobile_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, busy, overflow, tx;

  mobile_transmitter #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .full_o    (full),
    .busy_o    (busy),
    .overflow_o(overflow),
    .tx_o      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending bytes, byte on the line, frame position.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  bit         m_active;
  int         m_el;
  bit         m_ovf;

  // Expected frame levels, written out bit by bit.
  bit seq55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  bit seqbb [20] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1,
                     0, 1, 1, 1, 1, 0, 0, 0, 0, 1};

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       tx;
    logic       busy;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_el     = 0;
    m_ovf    = 0;
    m_cur    = 8'h00;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_edge();
    bit fullp, push, pop;
    fullp = (m_q.size() == DEPTH);
    push  = wr_en && !fullp;
    pop   = (m_q.size() != 0) && (!m_active || m_el == FRAME - 1);
    m_ovf = wr_en && fullp;
    if (m_active) begin
      m_el++;
      if (m_el == FRAME) m_active = 0;
    end
    if (pop) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_el     = 0;
    end
    if (push) m_q.push_back(wr_data);
  endtask

  function automatic logic m_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_el / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic step(input logic we, input logic [7:0] d);
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    model_edge();
    #1;
    chk("tx",       {7'd0, tx},       {7'd0, m_tx()});
    chk("busy",     {7'd0, busy},     {7'd0, (m_active || m_q.size() != 0)});
    chk("full",     {7'd0, full},     {7'd0, (m_q.size() == DEPTH)});
    chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    wr_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (!m_active && m_q.size() == 0) break;
      step(1'b0, 8'h00);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

    wr_en   = 1'b0;
    wr_data = 8'h00;
    rst_n   = 1'b0;
    model_reset();
    #23;
    chk("rst_tx",   {7'd0, tx},       8'h01);
    chk("rst_busy", {7'd0, busy},     8'h00);
    chk("rst_full", {7'd0, full},     8'h00);
    chk("rst_ovf",  {7'd0, overflow}, 8'h00);
    rst_n = 1'b1;

    // Overflow burst from idle: table of expected outputs per cycle.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].we, tbl[i].d);
      chk($sformatf("tbl%0d_tx", i),   {7'd0, tx},       {7'd0, tbl[i].tx});
      chk($sformatf("tbl%0d_busy", i), {7'd0, busy},     {7'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_full", i), {7'd0, full},     {7'd0, tbl[i].full});
      chk($sformatf("tbl%0d_ovf", i),  {7'd0, overflow}, {7'd0, tbl[i].ovf});
    end
    drain();

    // Single byte 0x55: 40 cycles of line level, then busy drops.
    step(1'b1, 8'h55);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 8'h00);
      chk($sformatf("f55_%0d", i), {7'd0, tx}, {7'd0, seq55[i / CPB]});
    end
    step(1'b0, 8'h00);
    chk("f55_busy_end", {7'd0, busy}, 8'h00);

    // Back-to-back 0xA3, 0x0F with no gap between frames.
    step(1'b1, 8'hA3);
    step(1'b1, 8'h0F);
    chk("bb_0", {7'd0, tx}, {7'd0, seqbb[0]});
    for (int i = 1; i < 2 * FRAME; i++) begin
      step(1'b0, 8'h00);
      chk($sformatf("bb_%0d", i), {7'd0, tx}, {7'd0, seqbb[i / CPB]});
    end
    step(1'b0, 8'h00);
    chk("bb_busy_end", {7'd0, busy}, 8'h00);

    // Write while full on the same cycle as the stop-boundary pop.
    for (int b = 0; b < 5; b++) step(1'b1, 8'h11 + 8'(b));
    chk("wf_full", {7'd0, full}, 8'h01);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_active && m_el == FRAME - 1) break;
      step(1'b0, 8'h00);
    end
    step(1'b1, 8'hEE);
    chk("wf_ovf",   {7'd0, overflow}, 8'h01);
    chk("wf_full2", {7'd0, full},     8'h00);
    chk("wf_start", {7'd0, tx},       8'h00);
    step(1'b0, 8'h00);
    chk("wf_ovf_pulse", {7'd0, overflow}, 8'h00);
    drain();

    // Reset in the middle of a frame, with a write attempted during reset.
    step(1'b1, 8'hC3);
    repeat (9) step(1'b0, 8'h00);
    #3;
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    #1;
    chk("mrst_tx",   {7'd0, tx},       8'h01);
    chk("mrst_busy", {7'd0, busy},     8'h00);
    chk("mrst_full", {7'd0, full},     8'h00);
    chk("mrst_ovf",  {7'd0, overflow}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_busy_wr", {7'd0, busy}, 8'h00);
    wr_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 8'h3C);
    drain();

    // Pointer wrap: ten spaced writes, never filling the FIFO.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h30 + 8'(i));
      repeat (FRAME + 2) step(1'b0, 8'h00);
    end

    // Randomized traffic, including bursts that hit the full condition.
    repeat (500) step(($urandom_range(0, 4) == 0), 8'($urandom));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
